// File: rtl/conv_accum.sv
// conv_accum
// ----------
// Window accumulator for the convolution engine. Each accepted product is
// added into a running sum through one shared 32-bit adder. After TAPS
// products the window sum is registered onto the output, together with a
// sticky carry-out flag, and offered over a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of the current window (also drops a held result)
//   in_valid   product available
//   in_ready   block can accept a product this cycle
//   in_data    unsigned product, WIDTH bits
//   out_valid  window result available
//   out_ready  consumer accepts the result
//   out_data   window sum modulo 2^WIDTH
//   out_ovf    at least one carry-out occurred while summing this window
//   tap_cnt    products accepted so far in the current window
module conv_accum #(
  parameter int WIDTH = 32,
  parameter int TAPS  = 9,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] tap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;

  logic               in_ready_s;
  logic               accept_s;
  logic               first_s;
  logic               consume_s;
  logic [WIDTH-1:0]   add_a_s;
  logic [WIDTH-1:0]   sum_s;
  logic               carry_s;
  logic               ovf_new_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               last_s;

  // A held result blocks new input unless it is being consumed this cycle,
  // which lets the next window start with no bubble.
  assign in_ready_s = (state_q != S_HOLD) | out_ready;
  assign accept_s   = in_valid & in_ready_s;
  assign consume_s  = (state_q == S_HOLD) & out_ready;

  // Outside ACCUM the accepted tap opens a new window: the adder's A input is
  // forced to zero so the product passes straight through and its carry is
  // meaningless.
  assign first_s   = (state_q != S_ACCUM);
  assign add_a_s   = first_s ? {WIDTH{1'b0}} : acc_q;
  assign {carry_s, sum_s} = {1'b0, add_a_s} + {1'b0, in_data};
  assign ovf_new_s = first_s ? 1'b0 : (ovf_q | carry_s);
  assign cnt_inc_s = first_s ? CNT_W'(1) : (cnt_q + CNT_W'(1));
  assign last_s    = (cnt_inc_s == CNT_W'(TAPS));

  // Next-state and datapath update: flush wins, otherwise consume then accept.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (flush) begin
      state_d     = S_IDLE;
      acc_d       = {WIDTH{1'b0}};
      ovf_d       = 1'b0;
      cnt_d       = {CNT_W{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (consume_s) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            state_d     = S_HOLD;
          end
        end
        S_IDLE, S_ACCUM: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (accept_s) begin
        acc_d = sum_s;
        ovf_d = ovf_new_s;
        // TAPS >= 2, so the completing tap is never a window's first tap.
        if (last_s) begin
          out_data_d  = sum_s;
          out_ovf_d   = ovf_new_s;
          out_valid_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = S_HOLD;
        end else begin
          cnt_d   = cnt_inc_s;
          state_d = S_ACCUM;
        end
      end else begin
        acc_d = acc_d;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= {WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign tap_cnt   = cnt_q;

endmodule

// File: tb/tb_conv_accum.sv
// Directed bench for conv_accum (TAPS=9). Inputs change on the falling edge,
// the DUT samples on the rising edge, outputs are checked on the falling edge.
module tb_conv_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_ovf;
  logic [7:0]  tap_cnt;

  int checks = 0;
  int fails  = 0;

  conv_accum #(.WIDTH(32), .TAPS(9), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .tap_cnt(tap_cnt)
  );

  always #5 clk = ~clk;

  // Present one tap for one cycle; caller is at a falling edge.
  task automatic feed(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin fails++; $display("FAIL reset_data: got %0h want 0", out_data); end
    checks++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0h want 0", out_ovf); end
    checks++; if (tap_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", tap_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) feed(32'(i));
    checks++; if (tap_cnt !== 8'd4) begin fails++; $display("FAIL basic_cnt4: got %0d want 4", tap_cnt); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %0h want 0", out_valid); end
    for (int i = 5; i <= 9; i++) feed(32'(i));
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0h want 1", out_valid); end
    checks++; if (out_data !== 32'd45) begin fails++; $display("FAIL basic_data: got %0d want 45", out_data); end
    checks++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %0h want 0", out_ovf); end
    checks++; if (tap_cnt !== 8'd0) begin fails++; $display("FAIL basic_cnt0: got %0d want 0", tap_cnt); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drop: got %0h want 0", out_valid); end
  endtask

  task automatic test_overflow;
    out_ready = 1'b1;
    feed(32'hFFFF_FFFF);
    feed(32'h0000_0001);
    for (int i = 0; i < 7; i++) feed(32'd0);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %0h want 1", out_valid); end
    checks++; if (out_data !== 32'd0) begin fails++; $display("FAIL ovf_data: got %0h want 0", out_data); end
    checks++; if (out_ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %0h want 1", out_ovf); end
    for (int i = 0; i < 9; i++) feed(32'd1);
    in_valid = 1'b0;
    checks++; if (out_data !== 32'd9) begin fails++; $display("FAIL ovf_next_data: got %0d want 9", out_data); end
    checks++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got %0h want 0", out_ovf); end
    idle(1);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) feed(32'(i));
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int k = 0; k < 10; k++) begin
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c%0d: got %0h want 0", k, in_ready); end
      checks++; if (out_data !== 32'd45 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold c%0d: got %0d/%0h want 45/1", k, out_data, out_valid); end
      checks++; if (tap_cnt !== 8'd0) begin fails++; $display("FAIL bp_cnt c%0d: got %0d want 0", k, tap_cnt); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_data   = 32'd7;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0h want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_consumed: got %0h want 0", out_valid); end
    checks++; if (tap_cnt !== 8'd1) begin fails++; $display("FAIL bp_cnt1: got %0d want 1", tap_cnt); end
    for (int i = 0; i < 8; i++) feed(32'd0);
    in_valid = 1'b0;
    checks++; if (out_data !== 32'd7 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_next_sum: got %0d/%0h want 7/1", out_data, out_valid); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    int hs = 0;
    int results = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 27; c++) begin
      in_valid = 1'b1;
      in_data  = 32'd2;
      #1;
      if (in_ready === 1'b1) hs++;
      @(negedge clk);
      if (out_valid === 1'b1) begin
        results++;
        checks++; if (out_data !== 32'd18) begin fails++; $display("FAIL stream_data r%0d: got %0d want 18", results, out_data); end
      end
    end
    in_valid = 1'b0;
    checks++; if (hs !== 27) begin fails++; $display("FAIL stream_handshakes: got %0d want 27", hs); end
    checks++; if (results !== 3) begin fails++; $display("FAIL stream_results: got %0d want 3", results); end
    idle(1);
  endtask

  task automatic test_flush;
    int results = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(32'd5);
    checks++; if (tap_cnt !== 8'd4) begin fails++; $display("FAIL flush_pre_cnt: got %0d want 4", tap_cnt); end
    flush = 1'b1;
    feed(32'd100);
    flush = 1'b0;
    checks++; if (tap_cnt !== 8'd0) begin fails++; $display("FAIL flush_cnt: got %0d want 0", tap_cnt); end
    for (int i = 0; i < 9; i++) begin
      feed(32'd1);
      if (out_valid === 1'b1) results++;
    end
    in_valid = 1'b0;
    checks++; if (results !== 1) begin fails++; $display("FAIL flush_results: got %0d want 1", results); end
    checks++; if (out_data !== 32'd9) begin fails++; $display("FAIL flush_sum: got %0d want 9", out_data); end
    idle(1);
    // Flush while a result is held discards it.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) feed(32'd1);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_hold_drop: got %0h want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) feed(32'd3);
    in_valid = 1'b0;
    checks++; if (tap_cnt !== 8'd6) begin fails++; $display("FAIL rst_mid_pre: got %0d want 6", tap_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (tap_cnt !== 8'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid: got cnt %0d valid %0h want 0/0", tap_cnt, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) feed(32'd3);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd27) begin fails++; $display("FAIL rst_hold_pre: got %0h/%0d want 1/27", out_valid, out_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || tap_cnt !== 8'd0) begin fails++; $display("FAIL rst_hold: got %0h/%0d/%0d want 0/0/0", out_valid, out_data, tap_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) feed(32'd3);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd27) begin fails++; $display("FAIL rst_after: got %0h/%0d want 1/27", out_valid, out_data); end
    idle(1);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_overflow;
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
